vram_wr_ctrl: RTL

//  Write-port controller for the 128x128x3 bitmap video RAM (2^14 x 3, dual-port sync).

---
 rtl/vram_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 44 ++++
 rtl/vram_wr_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the bitmap video RAM write path.
//   VRAM_ADDR_W / VRAM_DATA_W : RAM geometry ({y[6:0],x[6:0]} address, RGB pixel)
//   vram_state_e              : write-port controller state encoding
//   COL_*                     : commonly used fill colours
//   rr_pick()                 : 2-way round-robin grant decision
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 14;
  localparam int unsigned VRAM_DATA_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } vram_state_e;

  localparam logic [VRAM_DATA_W-1:0] COL_BLACK  = 3'b000;
  localparam logic [VRAM_DATA_W-1:0] COL_YELLOW = 3'b110;

  // last = index of the requester granted most recently. On contention the
  // other requester wins, which makes back-to-back requests alternate.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered "last granted" pointer.
//   clk, reset : clock, asynchronous active-high reset
//   en         : arbitration allowed this cycle (no grant when low)
//   req[1:0]   : request per requester
//   gnt[1:0]   : combinational one-hot (or zero) grant; a grant is an accepted transfer
// After reset the pointer says requester 1 was last, so requester 0 wins the first contention.
module rr_arb2
  import vram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      gnt = rr_pick(req, last_q);
    end
  end

  // A grant is always taken in the same cycle, so every grant moves the pointer.
  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/vram_wr_ctrl.sv
// Write-port controller for the bitmap video RAM (port A).
// Shares the single write port between two req/gnt requesters (round-robin) and
// contains a clear engine that fills every RAM word with one colour on command.
//   clk, reset              : clock, asynchronous active-high reset
//   clr_start, clr_color    : 1-cycle clear command and its fill colour
//   clr_busy                : clear engine owns the write port
//   clr_done                : 1-cycle pulse alongside the final clear write on the RAM port
//   req0/addr0/din0/gnt0    : requester 0 handshake (transfer when req && gnt at an edge)
//   req1/addr1/din1/gnt1    : requester 1 handshake
//   ram_we/ram_addr/ram_din : registered RAM port A write signals
module vram_wr_ctrl
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = VRAM_ADDR_W,
  parameter int unsigned DATA_WIDTH = VRAM_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_color,
  output logic                  clr_busy,
  output logic                  clr_done,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic                  gnt0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din
);

  localparam logic [ADDR_WIDTH-1:0] CntLast = '1;

  vram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  done_q, done_d;

  logic                  arb_en;
  logic [1:0]            arb_req;
  logic [1:0]            arb_gnt;

  // A clear command in IDLE takes priority over any request in the same cycle.
  assign arb_en  = (state_q == ST_IDLE) && !clr_start;
  assign arb_req = {req1, req0};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (arb_req),
    .gnt   (arb_gnt)
  );

  assign gnt0     = arb_gnt[0];
  assign gnt1     = arb_gnt[1];
  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = done_q;
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    we_d    = 1'b0;
    addr_d  = addr_q;  // address/data hold when nothing is written
    din_d   = din_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          fill_d  = clr_color;
          cnt_d   = '0;
        end else if (arb_gnt[0]) begin
          we_d   = 1'b1;
          addr_d = addr0;
          din_d  = din0;
        end else if (arb_gnt[1]) begin
          we_d   = 1'b1;
          addr_d = addr1;
          din_d  = din1;
        end
      end

      ST_CLEAR: begin
        // clr_start is ignored here: no restart, fill colour stays put.
        we_d   = 1'b1;
        addr_d = cnt_q;
        din_d  = fill_q;
        if (cnt_q == CntLast) begin
          // Final write registered now; done lines up with it on the RAM port.
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fill_q  <= COL_BLACK;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

endmodule
